// File: rtl/sample_window_averager_pkg.sv
// Shared helpers for the sample window averager: depth validation used at elaboration.
package sample_window_averager_pkg;

    // Window depth must be a power of two so divide-by-N is a plain right shift.
    function automatic bit is_valid_depth(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// N-deep circular sample buffer; presents the sample the next accept will evict (0 until full).
module sample_delay_line
    import sample_window_averager_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned N          = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic [data_width-1:0] data_in,
    output logic [data_width-1:0] oldest_out
);

    localparam int unsigned BITS = $clog2(N);
    localparam logic [BITS-1:0] PtrOne  = 1;
    localparam logic [BITS:0]   FillOne = 1;
    localparam logic [BITS:0]   FillMax = N[BITS:0];

    logic [data_width-1:0] mem [N];
    logic [BITS-1:0]       wr_ptr_q, wr_ptr_d;
    logic [BITS:0]         fill_q, fill_d;
    logic                  full;

    assign full = (fill_q == FillMax);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (read) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
            if (!full) begin
                fill_d = fill_q + FillOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage is never cleared; the fill counter masks stale contents after reset.
    always_ff @(posedge clk) begin
        if (read && !reset) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign oldest_out = full ? mem[wr_ptr_q] : '0;

endmodule

// File: rtl/sample_window_averager.sv
// Streaming boxcar averager: running sum of the last N accepted samples, output floor(sum / N).
module sample_window_averager
    import sample_window_averager_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter int unsigned N          = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic [data_width-1:0] data_in,
    output logic [data_width-1:0] data_out
);

    localparam int unsigned BITS  = $clog2(N);
    localparam int unsigned SUM_W = data_width + BITS;

    if (!is_valid_depth(N)) begin : gen_bad_depth
        $error("sample_window_averager: N must be a power of two and at least 2");
    end

    logic [data_width-1:0] oldest;
    logic [SUM_W-1:0]      sum_q, sum_d;

    sample_delay_line #(
        .data_width (data_width),
        .N          (N)
    ) u_delay_line (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .data_in    (data_in),
        .oldest_out (oldest)
    );

    // Evicted sample is already part of sum_q, so the subtraction never underflows.
    always_comb begin
        sum_d = sum_q;
        if (read) begin
            sum_d = sum_q + SUM_W'(data_in) - SUM_W'(oldest);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    always_comb begin
        data_out = data_width'(sum_q >> BITS);
    end

endmodule

// File: tb/tb_sample_window_averager.sv
// Self-checking bench: small-window and default-depth instances against a queue-based window model.
module tb_sample_window_averager;

    localparam int unsigned DW = 8;
    localparam int unsigned SN = 4;
    localparam int unsigned BN = 4096;

    logic          clk = 1'b0;
    logic          s_reset, s_read;
    logic [DW-1:0] s_din, s_dout;
    logic          b_reset, b_read;
    logic [DW-1:0] b_din, b_dout;

    int checks = 0;
    int errors = 0;
    int win_s[$];
    int win_b[$];

    always #5 clk = ~clk;

    sample_window_averager #(
        .data_width (DW),
        .N          (SN)
    ) u_dut_small (
        .clk      (clk),
        .reset    (s_reset),
        .read     (s_read),
        .data_in  (s_din),
        .data_out (s_dout)
    );

    sample_window_averager #(
        .data_width (DW),
        .N          (BN)
    ) u_dut_big (
        .clk      (clk),
        .reset    (b_reset),
        .read     (b_read),
        .data_in  (b_din),
        .data_out (b_dout)
    );

    function automatic int window_avg(input int w[$], input int n);
        int sum = 0;
        foreach (w[i]) sum += w[i];
        return sum / n;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input int exp);
        logic [DW-1:0] exp_v;
        exp_v = exp[DW-1:0];
        checks++;
        assert (got === exp_v)
        else begin
            errors++;
            $error("FAIL %s: data_out=%0d expected %0d", tag, got, exp_v);
        end
    endtask

    // One clock edge on the N=4 instance, then model update and comparison.
    task automatic small_step(input logic rst, input logic rd, input int d, input string tag);
        s_reset = rst;
        s_read  = rd;
        s_din   = d[DW-1:0];
        @(posedge clk);
        #1;
        if (rst) begin
            win_s.delete();
            repeat (SN) win_s.push_back(0);
        end else if (rd) begin
            win_s.push_front(d);
            void'(win_s.pop_back());
        end
        check(tag, s_dout, window_avg(win_s, SN));
    endtask

    task automatic big_step(input logic rst, input logic rd, input int d, input string tag);
        b_reset = rst;
        b_read  = rd;
        b_din   = d[DW-1:0];
        @(posedge clk);
        #1;
        if (rst) begin
            win_b.delete();
            repeat (BN) win_b.push_back(0);
        end else if (rd) begin
            win_b.push_front(d);
            void'(win_b.pop_back());
        end
        check(tag, b_dout, window_avg(win_b, BN));
    endtask

    initial begin
        s_reset = 1'b1;
        s_read  = 1'b0;
        s_din   = '0;
        b_reset = 1'b1;
        b_read  = 1'b1;
        b_din   = 8'd8;

        // Reset state
        small_step(1'b1, 1'b0, 0, "reset");
        small_step(1'b1, 1'b1, 99, "reset_read");
        check("big_reset_idle", b_dout, 0);

        // Fill phase, diluted average
        small_step(1'b0, 1'b1, 8, "fill8");
        small_step(1'b0, 1'b1, 16, "fill16");
        small_step(1'b0, 1'b1, 24, "fill24");
        small_step(1'b0, 1'b1, 64, "fill64");
        small_step(1'b0, 1'b1, 16, "evict16");
        small_step(1'b0, 1'b1, 8, "evict8");

        // Hold with toggling data
        for (int i = 0; i < 10; i++) begin
            small_step(1'b0, 1'b0, (i % 2 == 0) ? 8'hAA : 8'h55, "hold");
        end
        small_step(1'b0, 1'b1, 16, "after_hold");

        // Reset mid-stream wins over read
        small_step(1'b1, 1'b1, 200, "mid_reset");
        small_step(1'b0, 1'b1, 40, "post_reset");

        // Full scale
        small_step(1'b1, 1'b0, 0, "fs_reset");
        for (int i = 0; i < 4; i++) small_step(1'b0, 1'b1, 255, "full_scale");
        small_step(1'b0, 1'b1, 0, "fs_drop");

        // Randomized traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            small_step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 255)), "random");
        end

        // Default depth ramp: reset cycle with read high must not capture data_in
        s_read = 1'b0;
        big_step(1'b1, 1'b1, 8, "big_reset");
        for (int i = 1; i <= 4100; i++) begin
            big_step(1'b0, 1'b1, 8, "big_ramp");
        end
        for (int i = 0; i < 40; i++) begin
            big_step(1'b0, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 255)),
                     "big_random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
